// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: loader FSM states, word constants and image word extraction.
package lc3_pkg;

   localparam int                WORD_W       = 16;
   localparam logic [WORD_W-1:0] ORIG_DEFAULT = 16'h3000;
   localparam int                IMG_MAX_W    = 4096;

   typedef enum logic [2:0] {
      IDLE,
      ORIGIN,
      WRITE,
      VERIFY,
      DONE
   } state_t;

   // Word k of a flat image; word 0 sits in the least significant bits.
   function automatic logic [WORD_W-1:0] image_word(input logic [IMG_MAX_W-1:0] img,
                                                    input int unsigned          k);
      logic [IMG_MAX_W-1:0] shifted;
      shifted = img >> (k * WORD_W);
      return shifted[WORD_W-1:0];
   endfunction

endpackage

// File: rtl/lc3_image_shadow.sv
// Holds the object image latched at load acceptance and selects one program word.
module lc3_image_shadow
   import lc3_pkg::*;
#(
   parameter int SIZE  = 80,
   parameter int SEL_W = 3
) (
   input  logic              clk,
   input  logic              capture,
   input  logic [SIZE-1:0]   image,
   input  logic [SEL_W-1:0]  sel,
   output logic [WORD_W-1:0] origin,
   output logic [WORD_W-1:0] word
);

   logic [SIZE-1:0] shadow;

   always_ff @(posedge clk) begin
      if (capture) shadow <= image;
   end

   assign origin = shadow[WORD_W-1:0];
   assign word   = image_word(IMG_MAX_W'(shadow), 32'(sel));

endmodule

// File: rtl/lc3_prog_loader.sv
// Loads an LC-3 object image into memory over a ready/valid write port, then releases the core.
// Optional read-back verification of every write: define LOADER_READBACK_EN.
module lc3_prog_loader
   import lc3_pkg::*;
#(
   parameter  int SIZE   = 80,
   localparam int NWORDS = SIZE / WORD_W,
   localparam int CNT_W  = $clog2(NWORDS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [SIZE-1:0]   prog_image,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic              mem_ready,
`ifdef LOADER_READBACK_EN
   output logic              mem_re,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              load_err,
`endif
   output logic              busy,
   output logic              done,
   output logic              cpu_run,
   output logic [WORD_W-1:0] start_pc,
   output logic [CNT_W-1:0]  words_loaded
);

   state_t            state, state_nxt;
   logic              capture;
   logic              advance;
   logic              last;
   // idx always points at the word to be presented after the current one.
   logic [CNT_W-1:0]  idx, idx_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              we_nxt, busy_nxt, done_nxt;
   logic [WORD_W-1:0] addr_nxt, wdata_nxt, spc_nxt;
   logic [WORD_W-1:0] sh_origin, sh_word;
`ifdef LOADER_READBACK_EN
   logic              re_nxt, err_nxt;
`endif

   lc3_image_shadow #(
      .SIZE  (SIZE),
      .SEL_W (CNT_W)
   ) u_shadow (
      .clk     (clk),
      .capture (capture),
      .image   (prog_image),
      .sel     (idx),
      .origin  (sh_origin),
      .word    (sh_word)
   );

   assign last = (idx == CNT_W'(NWORDS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      advance   = 1'b0;
      we_nxt    = mem_we;
      addr_nxt  = mem_addr;
      wdata_nxt = mem_wdata;
      idx_nxt   = idx;
      cnt_nxt   = words_loaded;
      spc_nxt   = start_pc;
      busy_nxt  = busy;
      done_nxt  = done;
`ifdef LOADER_READBACK_EN
      re_nxt    = mem_re;
      err_nxt   = load_err;
`endif
      case (state)
         IDLE, DONE: begin
            if (load_start) begin
               capture   = 1'b1;
               state_nxt = ORIGIN;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
               cnt_nxt   = '0;
               idx_nxt   = CNT_W'(1);
`ifdef LOADER_READBACK_EN
               err_nxt   = 1'b0;
`endif
            end
         end
         ORIGIN: begin
            spc_nxt  = sh_origin;
            addr_nxt = sh_origin;
            if (NWORDS == 1) begin
               state_nxt = DONE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = WRITE;
               we_nxt    = 1'b1;
               wdata_nxt = sh_word;
               idx_nxt   = idx + CNT_W'(1);
            end
         end
         WRITE: begin
            if (mem_ready) begin
               cnt_nxt = words_loaded + CNT_W'(1);
               we_nxt  = 1'b0;
`ifdef LOADER_READBACK_EN
               state_nxt = VERIFY;
               re_nxt    = 1'b1;
`else
               advance   = 1'b1;
`endif
            end
         end
`ifdef LOADER_READBACK_EN
         VERIFY: begin
            if (mem_rvalid) begin
               re_nxt = 1'b0;
               if (mem_rdata != mem_wdata) begin
                  err_nxt   = 1'b1;
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  advance = 1'b1;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase

      // Move to the next word, or finish once the final word has been committed.
      if (advance) begin
         if (last) begin
            state_nxt = DONE;
            we_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
         end else begin
            state_nxt = WRITE;
            we_nxt    = 1'b1;
            addr_nxt  = mem_addr + 16'd1;
            wdata_nxt = sh_word;
            idx_nxt   = idx + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         idx          <= '0;
         words_loaded <= '0;
         start_pc     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
`ifdef LOADER_READBACK_EN
         mem_re       <= 1'b0;
         load_err     <= 1'b0;
`endif
      end else begin
         mem_we       <= we_nxt;
         mem_addr     <= addr_nxt;
         mem_wdata    <= wdata_nxt;
         idx          <= idx_nxt;
         words_loaded <= cnt_nxt;
         start_pc     <= spc_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
`ifdef LOADER_READBACK_EN
         mem_re       <= re_nxt;
         load_err     <= err_nxt;
`endif
      end
   end

`ifdef LOADER_READBACK_EN
   assign cpu_run = done & ~load_err;
`else
   assign cpu_run = done;
`endif

endmodule
